// File: rtl/simple_bus_pkg.sv
// Shared helpers for the simple_bus interconnect.
package simple_bus_pkg;

  // Width of an index selecting one of n ports; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simple_bus_arbiter.sv
// Fixed-priority arbiter: lowest-index requester wins. Provides both a
// one-hot grant vector and the binary index of the winner.
module simple_bus_arbiter #(
  parameter int unsigned N    = 1,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  // Scan from index 0 upwards; the first asserted request takes the grant.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        gnt[i] = 1'b1;
        idx    = IdxW'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_bus.sv
// simple_bus: combinationally arbitrated request/response interconnect.
// One host is granted per cycle, its address is decoded against per-device
// base/mask pairs, and the selected device's response one cycle later is
// routed back to the granted host.
module simple_bus
  import simple_bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],

  output logic                      device_req_o    [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
  output logic                      device_we_o     [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
  input  logic                      device_rvalid_i [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
  input  logic                      device_err_i    [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned HostSelW = sel_width(NrHosts);
  localparam int unsigned DevSelW  = sel_width(NrDevices);

  logic [NrHosts-1:0]      host_req_vec;
  logic [NrHosts-1:0]      host_gnt_vec;
  logic [HostSelW-1:0]     host_sel;
  logic                    host_sel_valid;

  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [DataWidth/8-1:0]  win_be;
  logic [DataWidth-1:0]    win_wdata;

  logic [DevSelW-1:0]      dev_sel;
  logic                    dev_hit;

  logic                    rsp_pending;
  logic [HostSelW-1:0]     rsp_host;
  logic [DevSelW-1:0]      rsp_dev;
  logic                    rsp_unmapped;

  logic                    sel_rvalid;
  logic [DataWidth-1:0]    sel_rdata;
  logic                    sel_err;

  // Pack the unpacked host request array for the arbiter.
  always_comb begin
    host_req_vec = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_req_vec[h] = host_req_i[h];
    end
  end

  simple_bus_arbiter #(
    .N    (NrHosts),
    .IdxW (HostSelW)
  ) u_host_arb (
    .req   (host_req_vec),
    .gnt   (host_gnt_vec),
    .idx   (host_sel),
    .valid (host_sel_valid)
  );

  // Grants go straight back to the hosts in the same cycle.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = host_gnt_vec[h];
    end
  end

  // Select the winning host's request fields.
  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (host_sel == HostSelW'(h)) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  // Address decode: lowest-index device whose masked address matches its base.
  always_comb begin
    dev_sel = '0;
    dev_hit = 1'b0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dev_hit && ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dev_sel = DevSelW'(d);
        dev_hit = 1'b1;
      end
    end
  end

  // Broadcast the winning fields to all devices; only the decoded one gets req.
  always_comb begin
    for (int unsigned d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = host_sel_valid && dev_hit && (dev_sel == DevSelW'(d));
      device_addr_o[d]  = win_addr;
      device_we_o[d]    = win_we;
      device_be_o[d]    = win_be;
      device_wdata_o[d] = win_wdata;
    end
  end

  // Remember who was granted and where the request went, for next-cycle routing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_pending  <= 1'b0;
      rsp_host     <= '0;
      rsp_dev      <= '0;
      rsp_unmapped <= 1'b0;
    end else begin
      rsp_pending  <= host_sel_valid;
      rsp_host     <= host_sel;
      rsp_dev      <= dev_sel;
      rsp_unmapped <= !dev_hit;
    end
  end

  // Pick the response source: the registered device, or a synthetic error
  // when the previous request decoded to nothing.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    sel_err    = 1'b0;
    if (rsp_unmapped) begin
      sel_rvalid = 1'b1;
      sel_err    = 1'b1;
    end else begin
      for (int unsigned d = 0; d < NrDevices; d++) begin
        if (rsp_dev == DevSelW'(d)) begin
          sel_rvalid = device_rvalid_i[d];
          sel_rdata  = device_rdata_i[d];
          sel_err    = device_err_i[d];
        end
      end
    end
  end

  // Deliver the response only to the host granted last cycle; others see zero.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (rsp_pending && (rsp_host == HostSelW'(h))) begin
        host_rvalid_o[h] = sel_rvalid;
        host_rdata_o[h]  = sel_rdata;
        host_err_o[h]    = sel_err;
      end else begin
        host_rvalid_o[h] = 1'b0;
        host_rdata_o[h]  = '0;
        host_err_o[h]    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// Directed, scoreboard-based bench for simple_bus with two hosts and three
// devices (RAM, SimCtrl, Timer).
module tb_simple_bus;

  localparam int unsigned NH = 2;
  localparam int unsigned ND = 3;

  logic        clk = 1'b0;
  logic        rst_i;

  logic        host_req_i    [NH];
  logic        host_gnt_o    [NH];
  logic [31:0] host_addr_i   [NH];
  logic        host_we_i     [NH];
  logic [3:0]  host_be_i     [NH];
  logic [31:0] host_wdata_i  [NH];
  logic        host_rvalid_o [NH];
  logic [31:0] host_rdata_o  [NH];
  logic        host_err_o    [NH];

  logic        device_req_o    [ND];
  logic [31:0] device_addr_o   [ND];
  logic        device_we_o     [ND];
  logic [3:0]  device_be_o     [ND];
  logic [31:0] device_wdata_o  [ND];
  logic        device_rvalid_i [ND];
  logic [31:0] device_rdata_i  [ND];
  logic        device_err_i    [ND];

  logic [31:0] cfg_device_addr_base [ND];
  logic [31:0] cfg_device_addr_mask [ND];

  typedef struct {
    int unsigned host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  simple_bus #(
    .NrDevices    (ND),
    .NrHosts      (NH),
    .DataWidth    (32),
    .AddressWidth (32)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .host_req_i           (host_req_i),
    .host_gnt_o           (host_gnt_o),
    .host_addr_i          (host_addr_i),
    .host_we_i            (host_we_i),
    .host_be_i            (host_be_i),
    .host_wdata_i         (host_wdata_i),
    .host_rvalid_o        (host_rvalid_o),
    .host_rdata_o         (host_rdata_o),
    .host_err_o           (host_err_o),
    .device_req_o         (device_req_o),
    .device_addr_o        (device_addr_o),
    .device_we_o          (device_we_o),
    .device_be_o          (device_be_o),
    .device_wdata_o       (device_wdata_o),
    .device_rvalid_i      (device_rvalid_i),
    .device_rdata_i       (device_rdata_i),
    .device_err_i         (device_err_i),
    .cfg_device_addr_base (cfg_device_addr_base),
    .cfg_device_addr_mask (cfg_device_addr_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_host(input int unsigned h, input logic req, input logic [31:0] addr,
                          input logic we, input logic [3:0] be, input logic [31:0] wdata);
    host_req_i[h]   = req;
    host_addr_i[h]  = addr;
    host_we_i[h]    = we;
    host_be_i[h]    = be;
    host_wdata_i[h] = wdata;
  endtask

  task automatic idle_hosts();
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic set_dev(input int unsigned d, input logic rv, input logic [31:0] rd, input logic er);
    device_rvalid_i[d] = rv;
    device_rdata_i[d]  = rd;
    device_err_i[d]    = er;
  endtask

  // Advance to just after the next rising edge; device responses default to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) set_dev(d, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [2:0] dreq();
    return {device_req_o[2], device_req_o[1], device_req_o[0]};
  endfunction

  task automatic push(input int unsigned h, input logic [31:0] rd, input logic er);
    exp_t e;
    e.host = h; e.rdata = rd; e.err = er;
    sb.push_back(e);
  endtask

  // Pop the oldest expected response and compare every host's response port.
  task automatic chk_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      for (int h = 0; h < NH; h++) begin
        if (h == int'(e.host)) begin
          chk($sformatf("%s_rvalid%0d", tag, h), host_rvalid_o[h], 1'b1);
          chk($sformatf("%s_rdata%0d", tag, h), host_rdata_o[h], e.rdata);
          chk($sformatf("%s_err%0d", tag, h), host_err_o[h], e.err);
        end else begin
          chk($sformatf("%s_rvalid%0d", tag, h), host_rvalid_o[h], 1'b0);
          chk($sformatf("%s_rdata%0d", tag, h), host_rdata_o[h], 32'h0);
          chk($sformatf("%s_err%0d", tag, h), host_err_o[h], 1'b0);
        end
      end
    end
  endtask

  initial begin
    cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = ~32'h000F_FFFF;
    cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = ~32'h0000_03FF;
    cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = ~32'h0000_03FF;
    idle_hosts();
    for (int d = 0; d < ND; d++) set_dev(d, 1'b0, 32'h0, 1'b0);

    // Reset: responses quiet while reset is held.
    rst_i = 1'b1;
    sample();
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("rst_rvalid%0d", h), host_rvalid_o[h], 1'b0);
      chk($sformatf("rst_err%0d", h), host_err_o[h], 1'b0);
      chk($sformatf("rst_rdata%0d", h), host_rdata_o[h], 32'h0);
    end
    tick();
    rst_i = 1'b0;
    sample();
    chk("idle_dreq", dreq(), 3'b000);
    chk("idle_gnt0", host_gnt_o[0], 1'b0);

    // Read from RAM by host 0.
    tick();
    set_host(0, 1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    sample();
    chk("rd_gnt0", host_gnt_o[0], 1'b1);
    chk("rd_dreq", dreq(), 3'b001);
    chk("rd_addr", device_addr_o[0], 32'h0010_0010);
    push(0, 32'hDEAD_BEEF, 1'b0);
    tick();
    idle_hosts();
    set_dev(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    sample();
    chk_rsp("rd_rsp");

    // Write to SimCtrl by host 0.
    tick();
    set_host(0, 1'b1, 32'h0002_0000, 1'b1, 4'hF, 32'h41);
    sample();
    chk("wr_gnt0", host_gnt_o[0], 1'b1);
    chk("wr_dreq", dreq(), 3'b010);
    chk("wr_we", device_we_o[1], 1'b1);
    chk("wr_be", device_be_o[1], 4'hF);
    chk("wr_wdata", device_wdata_o[1], 32'h41);
    push(0, 32'h0, 1'b0);
    tick();
    idle_hosts();
    set_dev(1, 1'b1, 32'h0, 1'b0);
    sample();
    chk_rsp("wr_rsp");

    // Timer raises an error.
    tick();
    set_host(0, 1'b1, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
    sample();
    chk("derr_dreq", dreq(), 3'b100);
    push(0, 32'h0000_0077, 1'b1);
    tick();
    idle_hosts();
    set_dev(2, 1'b1, 32'h0000_0077, 1'b1);
    sample();
    chk_rsp("derr_rsp");

    // Unmapped address: granted, no device request, synthetic error.
    tick();
    set_host(0, 1'b1, 32'h4000_0000, 1'b0, 4'hF, 32'h0);
    sample();
    chk("unm_gnt0", host_gnt_o[0], 1'b1);
    chk("unm_dreq", dreq(), 3'b000);
    push(0, 32'h0, 1'b1);
    tick();
    idle_hosts();
    set_dev(0, 1'b1, 32'h0000_1234, 1'b0);
    sample();
    chk_rsp("unm_rsp");

    // Stray device response with nothing pending is ignored.
    tick();
    set_dev(2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    sample();
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("stray_rvalid%0d", h), host_rvalid_o[h], 1'b0);
      chk($sformatf("stray_err%0d", h), host_err_o[h], 1'b0);
    end

    // Two hosts contend; then back-to-back pipelined reads.
    tick();
    set_host(0, 1'b1, 32'h0010_0020, 1'b0, 4'hF, 32'h0);
    set_host(1, 1'b1, 32'h0003_0008, 1'b0, 4'hF, 32'h0);
    sample();
    chk("arb_gnt0", host_gnt_o[0], 1'b1);
    chk("arb_gnt1", host_gnt_o[1], 1'b0);
    chk("arb_dreq", dreq(), 3'b001);
    chk("arb_addr", device_addr_o[2], 32'h0010_0020);
    push(0, 32'hCAFE_0001, 1'b0);

    tick();
    set_host(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_dev(0, 1'b1, 32'hCAFE_0001, 1'b0);
    sample();
    chk_rsp("pipe1_rsp");
    chk("pipe1_gnt0", host_gnt_o[0], 1'b0);
    chk("pipe1_gnt1", host_gnt_o[1], 1'b1);
    chk("pipe1_dreq", dreq(), 3'b100);
    chk("pipe1_addr", device_addr_o[2], 32'h0003_0008);
    push(1, 32'h0000_ABCD, 1'b0);

    tick();
    set_host(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_host(0, 1'b1, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    set_dev(2, 1'b1, 32'h0000_ABCD, 1'b0);
    sample();
    chk_rsp("pipe2_rsp");
    chk("pipe2_gnt0", host_gnt_o[0], 1'b1);
    chk("pipe2_dreq", dreq(), 3'b001);
    push(0, 32'h55AA_55AA, 1'b0);

    tick();
    idle_hosts();
    set_dev(0, 1'b1, 32'h55AA_55AA, 1'b0);
    sample();
    chk_rsp("pipe3_rsp");
    chk("pipe3_dreq", dreq(), 3'b000);

    // Reset while a response is pending drops it.
    tick();
    set_host(1, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    sample();
    chk("rstp_gnt1", host_gnt_o[1], 1'b1);
    tick();
    idle_hosts();
    rst_i = 1'b1;
    set_dev(0, 1'b1, 32'h1111_2222, 1'b0);
    sample();
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("rstp_rvalid%0d", h), host_rvalid_o[h], 1'b0);
      chk($sformatf("rstp_rdata%0d", h), host_rdata_o[h], 32'h0);
    end
    tick();
    rst_i = 1'b0;
    set_dev(0, 1'b1, 32'h1111_2222, 1'b0);
    sample();
    chk("rstp_after_rvalid1", host_rvalid_o[1], 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
